// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: issues one outstanding imem read at a time and buffers
// {pc, instr} pairs in a first-word-fall-through FIFO that feeds decode.
module fetch_queue_stage #(
  parameter int          XLEN       = 32,
  parameter int          ILEN       = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  output logic                          imem_we_re,
  output logic [3:0]                    imem_mask,
  input  logic                          imem_rsp_valid,
  input  logic [ILEN-1:0]               imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_target,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [ILEN-1:0]               dec_instr,
  output logic [XLEN-1:0]               dec_pc,
  output logic [XLEN-1:0]               dec_pc_plus4,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: a transfer happens on any cycle where valid && ready are both high;
  // the request address is held while valid && !ready unless a redirect arrives.
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q [FIFO_DEPTH];
  logic [ILEN-1:0] instr_mem_q [FIFO_DEPTH];

  logic accept, rsp_fire, push, pop;
  logic [CW:0] credit_used;

  // Entries already buffered plus the one still in flight must leave room.
  assign credit_used    = {1'b0, count_q} + (CW+1)'(outstanding_q);
  assign imem_req_valid = !rst && !redirect_valid && (!outstanding_q || imem_rsp_valid)
                          && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign imem_we_re     = 1'b0;
  assign imem_mask      = 4'b1111;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && outstanding_q;
  assign push     = rsp_fire && !drop_q && !redirect_valid;
  assign pop      = dec_valid && dec_ready;

  assign dec_valid    = (count_q != '0);
  assign dec_pc       = pc_mem_q[rd_ptr_q];
  assign dec_instr    = instr_mem_q[rd_ptr_q];
  assign dec_pc_plus4 = dec_pc + XLEN'(4);
  assign fifo_count   = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      if (rsp_fire) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end else if (outstanding_q) begin
        // The stale response is still coming; swallow it when it lands.
        drop_d = 1'b1;
      end
    end else begin
      if (accept) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
        outstanding_d = 1'b1;
      end else if (rsp_fire) begin
        outstanding_d = 1'b0;
      end
      if (rsp_fire) drop_d = 1'b0;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: 1-cycle memory model plus hand-computed
// expectations for streaming, backpressure, redirects and mid-run reset.
module tb_fetch_queue_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_we_re;
  logic [3:0]  imem_mask;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fails  = 0;
  logic mem_en;

  fetch_queue_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_we_re      (imem_we_re),
    .imem_mask       (imem_mask),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_pc_plus4    (dec_pc_plus4),
    .fifo_count      (fifo_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request handshake mid-cycle, then answer it after the edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = mem_en && acc;
    imem_rsp_data  = (mem_en && acc) ? mem_word(a) : 32'h0;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_target = '0; dec_ready = 1'b1; mem_en = 1'b1;
    tick(); tick();
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("we_re", 32'(imem_we_re), 32'd0);
    check("mask", 32'(imem_mask), 32'hF);

    // Streaming with single-cycle memory
    rst = 1'b0; #1;
    check("r0_req_valid", 32'(imem_req_valid), 32'd1);
    check("r0_addr", imem_req_addr, 32'h0);
    check("r0_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    check("r1_addr", imem_req_addr, 32'h4);
    check("r1_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("stream_dec_valid", 32'(dec_valid), 32'd1);
      check("stream_dec_pc", dec_pc, 32'(4*i));
      check("stream_dec_instr", dec_instr, mem_word(32'(4*i)));
      check("stream_pc_plus4", dec_pc_plus4, 32'(4*i + 4));
      check("stream_addr", imem_req_addr, 32'(4*i + 8));
      check("stream_count", 32'(fifo_count), 32'd1);
      tick();
    end

    // Decode stalls: buffer fills to depth, requests stop
    dec_ready = 1'b0;
    tick(); tick(); tick();
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    check("full_head_pc", dec_pc, 32'h18);
    tick();
    check("full_hold_count", 32'(fifo_count), 32'd4);
    check("full_hold_req_valid", 32'(imem_req_valid), 32'd0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0; #1;
    check("pop1_req_valid", 32'(imem_req_valid), 32'd1);
    check("pop1_addr", imem_req_addr, 32'h28);
    check("pop1_head_pc", dec_pc, 32'h1C);
    check("pop1_count", 32'(fifo_count), 32'd3);
    tick();
    check("credit_req_valid", 32'(imem_req_valid), 32'd0);
    check("credit_count", 32'(fifo_count), 32'd3);
    tick();
    check("refill_count", 32'(fifo_count), 32'd4);
    check("refill_req_valid", 32'(imem_req_valid), 32'd0);
    dec_ready = 1'b1; #1;
    check("drain_pc0", dec_pc, 32'h1C);
    tick();
    check("drain_pc1", dec_pc, 32'h20);
    check("drain_count", 32'(fifo_count), 32'd3);
    check("drain_addr", imem_req_addr, 32'h2C);
    tick();
    check("drain_pc2", dec_pc, 32'h24);
    tick();
    check("drain_pc3", dec_pc, 32'h28);
    check("drain_addr2", imem_req_addr, 32'h34);

    // Mid-run reset with 3 buffered and 1 outstanding
    dec_ready = 1'b0;
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    check("pre_rst_head", dec_pc, 32'h28);
    rst = 1'b1;
    tick();
    check("midrst_dec_valid", 32'(dec_valid), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b0; dec_ready = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0; #1;
    check("postrst_req_valid", 32'(imem_req_valid), 32'd1);
    check("postrst_addr", imem_req_addr, 32'h0);
    tick();
    check("stray_rsp_dec_valid", 32'(dec_valid), 32'd0);
    check("stray_rsp_count", 32'(fifo_count), 32'd0);
    tick();
    check("postrst_first_valid", 32'(dec_valid), 32'd1);
    check("postrst_first_pc", dec_pc, 32'h0);
    check("postrst_first_instr", dec_instr, mem_word(32'h0));

    // Redirect while 0x8 is outstanding with no response; pop coincides
    mem_en = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h100; #1;
    check("redir_req_valid", 32'(imem_req_valid), 32'd0);
    check("redir_head_pc", dec_pc, 32'h4);
    tick();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h8);
    mem_en = 1'b1; #1;
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_dec_valid", 32'(dec_valid), 32'd0);
    check("redir_addr", imem_req_addr, 32'h100);
    check("redir_addr_valid", 32'(imem_req_valid), 32'd1);
    tick();
    check("dropped_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    check("redir_dec_valid", 32'(dec_valid), 32'd1);
    check("redir_dec_pc", dec_pc, 32'h100);
    check("redir_dec_instr", dec_instr, mem_word(32'h100));

    // Redirect to unaligned target coincident with a response
    redirect_valid = 1'b1; redirect_target = 32'h203; #1;
    check("redir2_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    check("redir2_dec_valid", 32'(dec_valid), 32'd0);
    check("redir2_count", 32'(fifo_count), 32'd0);
    check("redir2_req_valid_after", 32'(imem_req_valid), 32'd1);
    check("redir2_addr", imem_req_addr, 32'h200);
    tick(); tick();
    check("redir2_dec_pc", dec_pc, 32'h200);
    check("redir2_dec_instr", dec_instr, mem_word(32'h200));

    // Memory not ready for 3 cycles: address held, no skip or repeat
    imem_req_ready = 1'b0;
    tick();
    check("stall_addr0", imem_req_addr, 32'h208);
    check("stall_valid0", 32'(imem_req_valid), 32'd1);
    check("stall_head", dec_pc, 32'h204);
    tick();
    check("stall_addr1", imem_req_addr, 32'h208);
    check("stall_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    check("stall_addr2", imem_req_addr, 32'h208);
    imem_req_ready = 1'b1;
    tick();
    check("resume_addr", imem_req_addr, 32'h20C);
    tick();
    check("resume_pc0", dec_pc, 32'h208);
    tick();
    check("resume_pc1", dec_pc, 32'h20C);
    check("resume_instr1", dec_instr, mem_word(32'h20C));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
